// File: rtl/qeciphy_pkg.sv
// Shared definitions for the QECIPHY MMCM reset controller: FSM state
// encoding and default timing parameters.
package qeciphy_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_READY  = 2'd2,
    ST_FAULT  = 2'd3
  } mmcm_state_e;

  localparam int unsigned DEF_RESET_CYCLES  = 64;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_HB_TIMEOUT    = 256;
  localparam int unsigned DEF_MAX_RETRIES   = 3;

endpackage

// File: rtl/qeciphy_sync_2ff.sv
// Two-flop synchroniser bringing a single asynchronous bit into the clk domain.
module qeciphy_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qeciphy_mmcm_rst_ctrl.sv
// MMCM reset sequencer: holds the MMCM in reset, waits for stable output,
// then supervises the output heartbeat and retries on failure up to a limit.
module qeciphy_mmcm_rst_ctrl
  import qeciphy_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned HB_TIMEOUT    = DEF_HB_TIMEOUT,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_clk_stopped,
  input  logic       clk_out_hb,
  input  logic       restart_req,
  output logic       mmcm_reset,
  output logic       clk_ready,
  output logic       fault,
  output logic [1:0] state
);

  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(4 * SETTLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HB_TIMEOUT + 1);
  localparam int unsigned YW = $clog2(MAX_RETRIES + 2);

  localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TOT_LAST   = TW'(4 * SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TOT_MAX    = TW'(4 * SETTLE_CYCLES);
  localparam logic [HW-1:0] HB_MAX     = HW'(HB_TIMEOUT);
  localparam logic [YW-1:0] RETRY_LIM  = YW'(MAX_RETRIES);
  localparam logic [YW-1:0] RETRY_MAX  = YW'(MAX_RETRIES + 1);

  logic stopped_s;
  logic hb_s;
  logic hb_edge;

  mmcm_state_e   state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] settle_tot_q, settle_tot_d;
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic [YW-1:0] retry_q, retry_d;
  logic          hb_prev_q, hb_seen_q, hb_seen_d;
  logic          mmcm_reset_q, clk_ready_q, fault_q;
  logic          attempt_fail;
  logic          new_attempt;

  qeciphy_sync_2ff u_sync_stopped (
    .clk (clk),
    .rst (rst),
    .d   (input_clk_stopped),
    .q   (stopped_s)
  );

  qeciphy_sync_2ff u_sync_hb (
    .clk (clk),
    .rst (rst),
    .d   (clk_out_hb),
    .q   (hb_s)
  );

  assign hb_edge = hb_s ^ hb_prev_q;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;

    case (state_q)
      ST_RESET:  if (rst_cnt_q == RST_LAST) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_MAX && hb_seen_q) state_d = ST_READY;
        else if (settle_tot_q == TOT_LAST)           attempt_fail = 1'b1;
      end
      ST_READY:  if (stopped_s || hb_cnt_q == HB_MAX) attempt_fail = 1'b1;
      ST_FAULT:  state_d = ST_FAULT;
      default:   state_d = ST_RESET;
    endcase

    if (attempt_fail) begin
      state_d = (retry_q >= RETRY_LIM) ? ST_FAULT : ST_RESET;
      retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;
    end
    if (state_d == ST_READY && state_q != ST_READY) retry_d = '0;
    if (restart_req) begin
      state_d = ST_RESET;
      retry_d = '0;
    end

    // Per-state counters run only while the FSM stays put; any transition or restart zeroes them.
    new_attempt  = restart_req || (state_d != state_q);
    rst_cnt_d    = '0;
    settle_cnt_d = '0;
    settle_tot_d = '0;
    hb_seen_d    = 1'b0;
    hb_cnt_d     = '0;
    if (!new_attempt) begin
      if (state_q == ST_RESET)
        rst_cnt_d = (rst_cnt_q == RST_LAST) ? rst_cnt_q : rst_cnt_q + 1'b1;
      if (state_q == ST_SETTLE) begin
        if (stopped_s)                      settle_cnt_d = '0;
        else if (settle_cnt_q == SETTLE_MAX) settle_cnt_d = settle_cnt_q;
        else                                 settle_cnt_d = settle_cnt_q + 1'b1;
        settle_tot_d = (settle_tot_q == TOT_MAX) ? settle_tot_q : settle_tot_q + 1'b1;
        hb_seen_d    = hb_seen_q | hb_edge;
      end
      if (state_q == ST_READY) begin
        if (hb_edge)                 hb_cnt_d = '0;
        else if (hb_cnt_q == HB_MAX) hb_cnt_d = hb_cnt_q;
        else                         hb_cnt_d = hb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RESET;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      settle_tot_q <= '0;
      hb_cnt_q     <= '0;
      retry_q      <= '0;
      hb_prev_q    <= 1'b0;
      hb_seen_q    <= 1'b0;
      mmcm_reset_q <= 1'b1;
      clk_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      settle_tot_q <= settle_tot_d;
      hb_cnt_q     <= hb_cnt_d;
      retry_q      <= retry_d;
      hb_prev_q    <= hb_s;
      hb_seen_q    <= hb_seen_d;
      mmcm_reset_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
      clk_ready_q  <= (state_d == ST_READY);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign mmcm_reset = mmcm_reset_q;
  assign clk_ready  = clk_ready_q;
  assign fault      = fault_q;
  assign state      = state_q;

endmodule

// File: tb/tb_qeciphy_mmcm_rst_ctrl.sv
// Directed bench for qeciphy_mmcm_rst_ctrl at default parameters.
module tb_qeciphy_mmcm_rst_ctrl;

  logic       clk;
  logic       rst;
  logic       input_clk_stopped;
  logic       clk_out_hb;
  logic       restart_req;
  logic       mmcm_reset;
  logic       clk_ready;
  logic       fault;
  logic [1:0] state;
  logic       hb_run;

  int vectors;
  int miscompares;

  qeciphy_mmcm_rst_ctrl #(
    .RESET_CYCLES  (64),
    .SETTLE_CYCLES (1024),
    .HB_TIMEOUT    (256),
    .MAX_RETRIES   (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .input_clk_stopped (input_clk_stopped),
    .clk_out_hb        (clk_out_hb),
    .restart_req       (restart_req),
    .mmcm_reset        (mmcm_reset),
    .clk_ready         (clk_ready),
    .fault             (fault),
    .state             (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Heartbeat toggles every 8 clk while hb_run is set.
  initial begin
    clk_out_hb = 1'b0;
    forever begin
      repeat (8) @(posedge clk);
      #2;
      if (hb_run) clk_out_hb = ~clk_out_hb;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_high(output int n);
    n = 0;
    while (mmcm_reset === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (clk_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (state !== 2'd0 || mmcm_reset !== 1'b1 || clk_ready !== 1'b0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got st=%0d rst=%0b rdy=%0b flt=%0b expected st=0 rst=1 rdy=0 flt=0",
               state, mmcm_reset, clk_ready, fault);
    end
    rst = 1'b0;
    measure_high(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL powerup_reset_len: got %0d expected 64", n);
    end
    wait_ready(n);
    vectors++;
    if (n != 1025 || state !== 2'd2) begin
      miscompares++;
      $display("FAIL powerup_settle: got %0d cycles st=%0d expected 1025 cycles st=2", n, state);
    end
  endtask

  task automatic test_stopped_pulse();
    int n;
    input_clk_stopped = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_ready === 1'b1 && n < 10);
    vectors++;
    if (n != 3 || state !== 2'd0 || mmcm_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL stopped_drop: got %0d cycles st=%0d rst=%0b expected 3 cycles st=0 rst=1",
               n, state, mmcm_reset);
    end
    n = 0;
    while (mmcm_reset === 1'b1 && n < 300) begin
      n++;
      if (n == 3) input_clk_stopped = 1'b0;
      tick();
    end
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL stopped_reset_len: got %0d expected 64", n);
    end
    wait_ready(n);
    vectors++;
    if (n != 1025) begin
      miscompares++;
      $display("FAIL stopped_resettle: got %0d expected 1025", n);
    end
  endtask

  task automatic test_hb_freeze();
    int n;
    logic prev;
    prev = clk_out_hb;
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_out_hb === prev && n < 20);
    vectors++;
    if (clk_out_hb === prev) begin
      miscompares++;
      $display("FAIL hb_toggle_seen: got %0b expected %0b", clk_out_hb, ~prev);
    end
    hb_run = 1'b0;
    n = 0;
    while (clk_ready === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    vectors++;
    if (n < 256 || n > 262) begin
      miscompares++;
      $display("FAIL hb_timeout: got %0d expected 256..262", n);
    end
    vectors++;
    if (state !== 2'd0 || mmcm_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL hb_to_reset: got st=%0d rst=%0b expected st=0 rst=1", state, mmcm_reset);
    end
    hb_run = 1'b1;
    measure_high(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL hb_reset_len: got %0d expected 64", n);
    end
    wait_ready(n);
    vectors++;
    if (n != 1025) begin
      miscompares++;
      $display("FAIL hb_resettle: got %0d expected 1025", n);
    end
  endtask

  task automatic test_stopped_permanent();
    int n;
    int rises;
    int resets;
    logic prev_rst;
    logic [1:0] prev_st;
    input_clk_stopped = 1'b1;
    rises = 0;
    resets = 0;
    n = 0;
    prev_rst = mmcm_reset;
    prev_st = state;
    while (fault !== 1'b1 && n < 20000) begin
      tick();
      n++;
      if (mmcm_reset === 1'b1 && prev_rst === 1'b0) rises++;
      if (state === 2'd0 && prev_st !== 2'd0) resets++;
      prev_rst = mmcm_reset;
      prev_st = state;
    end
    vectors++;
    if (rises != 4 || resets != 3) begin
      miscompares++;
      $display("FAIL retry_count: got rises=%0d resets=%0d expected rises=4 resets=3", rises, resets);
    end
    vectors++;
    if (fault !== 1'b1 || state !== 2'd3 || mmcm_reset !== 1'b1 || clk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_entry: got flt=%0b st=%0d rst=%0b rdy=%0b expected flt=1 st=3 rst=1 rdy=0",
               fault, state, mmcm_reset, clk_ready);
    end
    repeat (300) tick();
    vectors++;
    if (fault !== 1'b1 || state !== 2'd3 || mmcm_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_sticky: got flt=%0b st=%0d rst=%0b expected flt=1 st=3 rst=1",
               fault, state, mmcm_reset);
    end
  endtask

  task automatic test_restart();
    int n;
    restart_req = 1'b1;
    input_clk_stopped = 1'b0;
    tick();
    restart_req = 1'b0;
    vectors++;
    if (fault !== 1'b0 || state !== 2'd0 || mmcm_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_clear: got flt=%0b st=%0d rst=%0b expected flt=0 st=0 rst=1",
               fault, state, mmcm_reset);
    end
    measure_high(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL restart_reset_len: got %0d expected 64", n);
    end
    wait_ready(n);
    vectors++;
    if (n != 1025 || state !== 2'd2) begin
      miscompares++;
      $display("FAIL restart_ready: got %0d cycles st=%0d expected 1025 cycles st=2", n, state);
    end
  endtask

  task automatic test_rst_mid_settle();
    int n;
    restart_req = 1'b1;
    tick();
    restart_req = 1'b0;
    vectors++;
    if (state !== 2'd0 || clk_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_restart: got st=%0d rdy=%0b expected st=0 rdy=0", state, clk_ready);
    end
    measure_high(n);
    vectors++;
    if (n != 64 || state !== 2'd1) begin
      miscompares++;
      $display("FAIL settle_entry: got %0d cycles st=%0d expected 64 cycles st=1", n, state);
    end
    repeat (500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (state !== 2'd0 || mmcm_reset !== 1'b1 || clk_ready !== 1'b0 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort: got st=%0d rst=%0b rdy=%0b flt=%0b expected st=0 rst=1 rdy=0 flt=0",
               state, mmcm_reset, clk_ready, fault);
    end
    measure_high(n);
    vectors++;
    if (n != 64) begin
      miscompares++;
      $display("FAIL rst_reset_len: got %0d expected 64", n);
    end
    wait_ready(n);
    vectors++;
    if (n != 1025) begin
      miscompares++;
      $display("FAIL rst_resettle: got %0d expected 1025", n);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    input_clk_stopped = 1'b0;
    restart_req = 1'b0;
    hb_run = 1'b1;
    test_reset();
    test_stopped_pulse();
    test_hb_freeze();
    test_stopped_permanent();
    test_restart();
    test_rst_mid_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qeciphy_mmcm_rst_ctrl.md
QECIPHY_MMCM_RST_CTRL -- requirements
Module: qeciphy_mmcm_rst_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 64: cycles the MMCM reset is held asserted per attempt.
REQ-002 Parameter SETTLE_CYCLES, default 1024: consecutive clean cycles needed before declaring ready.
REQ-003 Parameter HB_TIMEOUT, default 256: maximum cycles between heartbeat edges while ready.
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts allowed before fault.
REQ-005 clk  input  1  free-running controller clock; the block has one clock and all logic is in this domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 input_clk_stopped  input  1  MMCM input-clock-stopped flag; asynchronous to clk.
REQ-008 clk_out_hb  input  1  heartbeat; toggles once per 16 clk_out cycles; asynchronous to clk.
REQ-009 restart_req  input  1  single-cycle request to restart from RESET; also clears fault.
REQ-010 mmcm_reset  output  1  drives the MMCM reset input.
REQ-011 clk_ready  output  1  high while MMCM outputs are deemed stable.
REQ-012 fault  output  1  high when retries are exhausted; sticky.
REQ-013 state  output  2  current FSM state encoding, for debug.

Function
REQ-014 input_clk_stopped and clk_out_hb shall each pass through a 2-flop synchroniser; all decisions use synchronised values only.
REQ-015 A heartbeat edge is any change of synchronised clk_out_hb versus its previous-cycle value.
REQ-016 States are RESET=0, SETTLE=1, READY=2, FAULT=3.
REQ-017 RESET: mmcm_reset=1; after exactly RESET_CYCLES cycles in RESET, go to SETTLE.
REQ-018 SETTLE: mmcm_reset=0; the settle counter increments on cycles with stopped=0 and clears on stopped=1.
REQ-019 SETTLE: the block goes to READY when the settle counter reaches SETTLE_CYCLES and at least one heartbeat edge has been seen since entering SETTLE.
REQ-020 SETTLE: after 4*SETTLE_CYCLES total cycles without meeting REQ-019, the attempt fails.
REQ-021 READY: clk_ready=1; the heartbeat counter clears on each edge.
REQ-022 READY: stopped=1, or the heartbeat counter reaching HB_TIMEOUT, counts as a failed attempt.
REQ-023 On a failed attempt, the retry counter increments; the block goes to RESET if the new count is at most MAX_RETRIES, otherwise to FAULT.
REQ-024 The retry counter clears on entering READY.
REQ-025 FAULT: mmcm_reset=1, clk_ready=0, fault=1; the block leaves FAULT only via restart_req or rst.
REQ-026 restart_req in any state goes to RESET next cycle, clears the retry counter and fault, and takes priority over the REQ-023 transitions in the same cycle.
REQ-027 Outputs are registered; clk_ready drops the cycle after the failure condition is seen in READY.
REQ-028 Counter widths are $clog2 of the maximum count plus 1; counters saturate and never wrap.

Reset
REQ-029 On rst: state=RESET, mmcm_reset=1, clk_ready=0, fault=0, all counters 0, synchroniser flops 0.
REQ-030 rst asserted mid-operation shall abort any state within one cycle and start a new RESET of full RESET_CYCLES.

Structure
REQ-031 The state enum and default parameter constants shall live in qeciphy_pkg.
REQ-032 The 2-flop synchroniser shall be one sub-module, qeciphy_sync_2ff, instantiated twice; everything else is in a single FSM module.

Verification
REQ-033 Power-up with stopped=0 and heartbeat toggling every 8 clk: mmcm_reset high for exactly 64 cycles, then clk_ready rises 1024 cycles (+/- sync latency) later.
REQ-034 In READY, pulse stopped=1 for 5 cycles: clk_ready falls within 3 cycles, mmcm_reset is reasserted for 64 cycles, and the block re-settles to READY.
REQ-035 In READY, freeze the heartbeat: clk_ready falls after 256 cycles (+ sync latency) and a RESET follows.
REQ-036 Hold stopped=1 permanently: 4 failed attempts, then fault=1, state=3 and mmcm_reset=1 held indefinitely.
REQ-037 In FAULT, pulse restart_req: fault clears next cycle and a full RESET->SETTLE->READY sequence completes once stopped=0.
REQ-038 Assert rst while in SETTLE at count 500: state returns to RESET next cycle and the counters restart from 0.
